// File: rtl/clk_tick_gen_multi.sv
// Multi-channel tick / divided-clock generator with per-channel runtime divisors.
// Latency: first tick registered div_act+1 edges after a channel starts at cnt=0; div_rd lags one cycle.
// Backpressure: none; config writes always accepted; active divisor changes only at a period boundary.
module clk_tick_gen_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 49999
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic                      sync,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]          cfg_div,
    output logic [NUM_CH-1:0]         cfg_pending,
    output logic [CNT_W-1:0]          div_rd,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_CH-1:0]         clk_out
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0]  cnt_q      [NUM_CH];
    logic [CNT_W-1:0]  cnt_d      [NUM_CH];
    logic [CNT_W-1:0]  div_act_q  [NUM_CH];
    logic [CNT_W-1:0]  div_act_d  [NUM_CH];
    logic [CNT_W-1:0]  div_pend_q [NUM_CH];
    logic [CNT_W-1:0]  div_pend_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] pend_d;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] tick_d;
    logic [NUM_CH-1:0] clk_out_q;
    logic [NUM_CH-1:0] clk_out_d;
    logic [CNT_W-1:0]  div_rd_q;
    logic [CNT_W-1:0]  div_rd_d;
    logic [NUM_CH-1:0] apply;

    // Per-channel next state: disable beats sync beats counting; a period boundary
    // (wrap, disable or sync) is the only point where a pending divisor becomes active.
    always_comb begin
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        tick_d     = '0;
        clk_out_d  = clk_out_q;
        apply      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!ch_en[i] || sync) begin
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
                apply[i]     = pend_q[i];
            end else if (cnt_q[i] == div_act_q[i]) begin
                cnt_d[i]     = '0;
                tick_d[i]    = 1'b1;
                clk_out_d[i] = ~clk_out_q[i];
                apply[i]     = pend_q[i];
            end else begin
                cnt_d[i]     = cnt_q[i] + CNT_W'(1);
            end
            if (apply[i]) begin
                div_act_d[i] = div_pend_q[i];
                pend_d[i]    = 1'b0;
            end
            // A write landing on a boundary edge re-arms pend after the old value is applied.
            if (cfg_we && (32'(cfg_ch) == i)) begin
                div_pend_d[i] = cfg_div;
                pend_d[i]     = 1'b1;
            end
        end
    end

    // Readback of the active divisor; unmapped channel numbers read as zero.
    always_comb begin
        div_rd_d = '0;
        if (32'(cfg_ch) < NUM_CH) begin
            div_rd_d = div_act_q[cfg_ch];
        end
    end

    // State registers with synchronous reset; reset aborts any period in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]      <= '0;
                div_act_q[i]  <= DIV_RST;
                div_pend_q[i] <= DIV_RST;
            end
            pend_q    <= '0;
            tick_q    <= '0;
            clk_out_q <= '0;
            div_rd_q  <= DIV_RST;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            clk_out_q  <= clk_out_d;
            div_rd_q   <= div_rd_d;
        end
    end

    assign cfg_pending = pend_q;
    assign div_rd      = div_rd_q;
    assign tick        = tick_q;
    assign clk_out     = clk_out_q;

endmodule

// File: tb/tb_clk_tick_gen_multi.sv
// Testbench for clk_tick_gen_multi: directed scenarios plus randomized traffic.
// Reference model tracks each channel by the absolute edge at which its period started.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_clk_tick_gen_multi;

    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int DEF = 3;

    logic              clk;
    logic              rst;
    logic [NCH-1:0]    ch_en;
    logic              sync;
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic [CW-1:0]     cfg_div;
    logic [NCH-1:0]    cfg_pending;
    logic [CW-1:0]     div_rd;
    logic [NCH-1:0]    tick;
    logic [NCH-1:0]    clk_out;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int             edge_n = 0;
    int             m_act    [NCH];
    int             m_pval   [NCH];
    int             m_anchor [NCH];
    logic [NCH-1:0] m_pend = '0;
    logic [NCH-1:0] m_tick = '0;
    logic [NCH-1:0] m_clk  = '0;
    logic [CW-1:0]  m_div_rd = '0;

    wire [3*NCH+CW-1:0] dut_vec = {tick, clk_out, cfg_pending, div_rd};

    clk_tick_gen_multi #(
        .NUM_CH     (NCH),
        .CNT_W      (CW),
        .DEFAULT_DIV(DEF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_en      (ch_en),
        .sync       (sync),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_pending(cfg_pending),
        .div_rd     (div_rd),
        .tick       (tick),
        .clk_out    (clk_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3*NCH+CW-1:0] exp_vec();
        return {m_tick, m_clk, m_pend, m_div_rd};
    endfunction

    // One clock edge of the reference: a channel's period ends when the edge
    // count since its last restart reaches divisor+1.
    task automatic model_edge();
        edge_n++;
        if (rst) m_div_rd = CW'(DEF);
        else if (int'(cfg_ch) < NCH) m_div_rd = CW'(m_act[cfg_ch]);
        else m_div_rd = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rst) begin
                m_act[i] = DEF; m_pval[i] = DEF; m_pend[i] = 1'b0;
                m_tick[i] = 1'b0; m_clk[i] = 1'b0; m_anchor[i] = edge_n;
            end else begin
                bit boundary;
                boundary = 1'b0;
                if (!ch_en[i] || sync) begin
                    m_anchor[i] = edge_n; m_tick[i] = 1'b0; m_clk[i] = 1'b0;
                    boundary = 1'b1;
                end else if (edge_n - m_anchor[i] == m_act[i] + 1) begin
                    m_anchor[i] = edge_n; m_tick[i] = 1'b1; m_clk[i] = ~m_clk[i];
                    boundary = 1'b1;
                end else begin
                    m_tick[i] = 1'b0;
                end
                if (boundary && m_pend[i]) begin
                    m_act[i] = m_pval[i]; m_pend[i] = 1'b0;
                end
                if (cfg_we && int'(cfg_ch) == i) begin
                    m_pval[i] = int'(cfg_div); m_pend[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        sync = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_div = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ch_en = '1; idle_inputs();
        step(); step();
        checks++; if (tick !== 3'b000) begin failures++; $display("FAIL reset_tick got=%b exp=000", tick); end
        checks++; if (clk_out !== 3'b000) begin failures++; $display("FAIL reset_clk_out got=%b exp=000", clk_out); end
        checks++; if (cfg_pending !== 3'b000) begin failures++; $display("FAIL reset_pending got=%b exp=000", cfg_pending); end
        checks++; if (div_rd !== 8'd3) begin failures++; $display("FAIL reset_div_rd got=%0d exp=3", div_rd); end
        checks++; if (dut_vec !== exp_vec()) begin failures++; $display("FAIL reset_model got=%h exp=%h", dut_vec, exp_vec()); end
        rst = 1'b0;
    endtask

    task automatic test_single_channel();
        int first = -1, n0 = 0, other = 0;
        ch_en = 3'b001; idle_inputs();
        for (int c = 1; c <= 24; c++) begin
            step();
            checks++; if (dut_vec !== exp_vec()) begin failures++; $display("FAIL single_model edge=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
            if (tick[0]) begin n0++; if (first < 0) first = c; end
            if (tick[2:1] != 2'b00 || clk_out[2:1] != 2'b00) other++;
        end
        checks++; if (first != 4) begin failures++; $display("FAIL single_first_tick got=%0d exp=4", first); end
        checks++; if (n0 != 6) begin failures++; $display("FAIL single_tick_count got=%0d exp=6", n0); end
        checks++; if (other != 0) begin failures++; $display("FAIL single_idle_channels got=%0d exp=0", other); end
        checks++; if (clk_out[0] !== 1'b0) begin failures++; $display("FAIL single_clk_out got=%b exp=0", clk_out[0]); end
    endtask

    task automatic test_div_change();
        int n = 0;
        idle_inputs(); do_reset(); ch_en = 3'b001;
        repeat (5) step();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd1;
        step();
        cfg_we = 1'b0;
        checks++; if (cfg_pending[0] !== 1'b1) begin failures++; $display("FAIL divchg_pend_set got=%b exp=1", cfg_pending[0]); end
        for (int e = 7; e <= 13; e++) begin
            step();
            checks++; if (dut_vec !== exp_vec()) begin failures++; $display("FAIL divchg_model edge=%0d got=%h exp=%h", e, dut_vec, exp_vec()); end
            if (tick[0]) n++;
            if (e == 7) begin
                checks++; if (cfg_pending[0] !== 1'b1 || tick[0] !== 1'b0) begin failures++; $display("FAIL divchg_edge7 got=pend%b/tick%b exp=pend1/tick0", cfg_pending[0], tick[0]); end
            end
            if (e == 8) begin
                checks++; if (cfg_pending[0] !== 1'b0 || tick[0] !== 1'b1) begin failures++; $display("FAIL divchg_edge8 got=pend%b/tick%b exp=pend0/tick1", cfg_pending[0], tick[0]); end
            end
        end
        checks++; if (n != 3) begin failures++; $display("FAIL divchg_tick_count got=%0d exp=3", n); end
    endtask

    task automatic test_disabled_write();
        int n = 0, tog = 0;
        logic prev;
        idle_inputs(); do_reset(); ch_en = 3'b000;
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd0;
        step();
        cfg_we = 1'b0;
        checks++; if (cfg_pending[1] !== 1'b1) begin failures++; $display("FAIL dis_pend_set got=%b exp=1", cfg_pending[1]); end
        step();
        checks++; if (cfg_pending[1] !== 1'b0) begin failures++; $display("FAIL dis_pend_clear got=%b exp=0", cfg_pending[1]); end
        step();
        checks++; if (div_rd !== 8'd0) begin failures++; $display("FAIL dis_div_rd got=%0d exp=0", div_rd); end
        ch_en = 3'b010;
        prev = clk_out[1];
        for (int c = 1; c <= 6; c++) begin
            step();
            checks++; if (dut_vec !== exp_vec()) begin failures++; $display("FAIL dis_model edge=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
            if (tick[1]) n++;
            if (clk_out[1] !== prev) tog++;
            prev = clk_out[1];
        end
        checks++; if (n != 6) begin failures++; $display("FAIL dis_tick_high got=%0d exp=6", n); end
        checks++; if (tog != 6) begin failures++; $display("FAIL dis_clk_toggles got=%0d exp=6", tog); end
    endtask

    task automatic test_sync();
        int f0 = -1, f1 = -1;
        idle_inputs(); do_reset(); ch_en = 3'b000;
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5;
        step();
        cfg_we = 1'b0;
        step();
        ch_en = 3'b011;
        repeat (5 + $urandom_range(0, 11)) begin
            step();
            checks++; if (dut_vec !== exp_vec()) begin failures++; $display("FAIL sync_run_model got=%h exp=%h", dut_vec, exp_vec()); end
        end
        sync = 1'b1;
        step();
        sync = 1'b0;
        checks++; if (clk_out[1:0] !== 2'b00 || tick[1:0] !== 2'b00) begin failures++; $display("FAIL sync_clear got=clk%b/tick%b exp=00/00", clk_out[1:0], tick[1:0]); end
        for (int c = 1; c <= 8; c++) begin
            step();
            checks++; if (dut_vec !== exp_vec()) begin failures++; $display("FAIL sync_model edge=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
            if (tick[0] && f0 < 0) f0 = c;
            if (tick[1] && f1 < 0) f1 = c;
        end
        checks++; if (f0 != 4) begin failures++; $display("FAIL sync_ch0_first got=%0d exp=4", f0); end
        checks++; if (f1 != 6) begin failures++; $display("FAIL sync_ch1_first got=%0d exp=6", f1); end
    endtask

    task automatic test_wrap_write();
        int tq[$];
        idle_inputs(); do_reset(); ch_en = 3'b001;
        repeat (3) step();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd7;
        step();
        cfg_we = 1'b0;
        checks++; if (tick[0] !== 1'b1 || cfg_pending[0] !== 1'b1) begin failures++; $display("FAIL wrapwr_edge4 got=tick%b/pend%b exp=1/1", tick[0], cfg_pending[0]); end
        for (int e = 5; e <= 17; e++) begin
            step();
            checks++; if (dut_vec !== exp_vec()) begin failures++; $display("FAIL wrapwr_model edge=%0d got=%h exp=%h", e, dut_vec, exp_vec()); end
            if (tick[0]) tq.push_back(e);
        end
        checks++; if (tq.size() != 2 || tq[0] != 8 || tq[1] != 16) begin failures++; $display("FAIL wrapwr_tick_edges got=%p exp=8,16", tq); end
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd9;
        step();
        cfg_we = 1'b0;
        checks++; if (cfg_pending !== 3'b000) begin failures++; $display("FAIL oor_pending got=%b exp=000", cfg_pending); end
        checks++; if (div_rd !== 8'd0) begin failures++; $display("FAIL oor_div_rd got=%0d exp=0", div_rd); end
        cfg_ch = 2'd0;
        step();
        checks++; if (div_rd !== 8'd7) begin failures++; $display("FAIL oor_ch0_div got=%0d exp=7", div_rd); end
    endtask

    task automatic test_reset_mid();
        idle_inputs(); do_reset(); ch_en = 3'b111;
        repeat (2) step();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd6; step();
        cfg_ch = 2'd2; cfg_div = 8'd2; step();
        cfg_ch = 2'd1; cfg_div = 8'd4; step();
        cfg_we = 1'b0; cfg_ch = 2'd0;
        checks++; if (cfg_pending !== 3'b110) begin failures++; $display("FAIL rmid_pend_before got=%b exp=110", cfg_pending); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (cfg_pending !== 3'b000 || tick !== 3'b000 || clk_out !== 3'b000) begin failures++; $display("FAIL rmid_clear got=pend%b/tick%b/clk%b exp=000/000/000", cfg_pending, tick, clk_out); end
        checks++; if (div_rd !== 8'd3) begin failures++; $display("FAIL rmid_div_rd got=%0d exp=3", div_rd); end
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++; if (tick !== ((c == 4) ? 3'b111 : 3'b000)) begin failures++; $display("FAIL rmid_restart edge=%0d got=%b", c, tick); end
            checks++; if (dut_vec !== exp_vec()) begin failures++; $display("FAIL rmid_model edge=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
        end
    endtask

    task automatic test_random();
        idle_inputs(); do_reset(); ch_en = 3'b111;
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) ch_en[$urandom_range(0, NCH-1)] ^= 1'b1;
            sync    = ($urandom_range(0, 59) == 0);
            cfg_we  = ($urandom_range(0, 7) == 0);
            cfg_ch  = 2'($urandom_range(0, 3));
            cfg_div = CW'($urandom_range(0, 6));
            step();
            checks++; if (dut_vec !== exp_vec()) begin failures++; $display("FAIL random_model cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
        end
        idle_inputs(); rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ch_en = '0; idle_inputs();
        for (int i = 0; i < NCH; i++) begin
            m_act[i] = DEF; m_pval[i] = DEF; m_anchor[i] = 0;
        end
        #1;
        test_reset();
        test_single_channel();
        test_div_change();
        test_disabled_write();
        test_sync();
        test_wrap_write();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
